// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing defaults, coordinate type and decode helper.
package vga_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_PIPE_DLY = 2;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test done at 32 bits so a window ending at 1024 still works.
  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset value; DEPTH of 0 is a wire.
module vga_delay_line #(
  parameter int unsigned          WIDTH     = 1,
  parameter int unsigned          DEPTH     = 2,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    assign o_data = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
      end else begin
        r_stage[0] <= i_data;
        for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: DrawX/DrawY, blank, active-low syncs and frame strobes.
// Define VGA_PIPE_ALIGN_EN to delay hs/vs/blank by PIPE_DLY cycles for pipelined renderers.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned PIPE_DLY  = DEF_PIPE_DLY
) (
  input  logic   vga_clk,
  input  logic   reset,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   frame_start,
  output logic   vblank_start
);

  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_LO = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_HI = H_VISIBLE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_LO = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_HI = V_VISIBLE + V_FP + V_SYNC;
  localparam coord_t      H_LAST    = coord_t'(H_TOTAL - 1);
  localparam coord_t      V_LAST    = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX || PIPE_DLY > 16) begin : g_bad_timing
    $error("vga_timing_gen: totals must fit 10-bit coordinates and PIPE_DLY <= 16");
  end

  coord_t r_hc;
  coord_t r_vc;
  logic   r_blank;
  logic   r_hs;
  logic   r_vs;
  logic   r_frame_start;
  logic   r_vblank_start;

  logic   w_h_last;
  logic   w_v_last;
  coord_t w_hc_nxt;
  coord_t w_vc_nxt;

  // Next raster position; the decodes below are taken from it so they line up with DrawX/DrawY.
  always_comb begin
    w_h_last = (r_hc == H_LAST);
    w_v_last = (r_vc == V_LAST);
    w_hc_nxt = w_h_last ? '0 : r_hc + coord_t'(1);
    w_vc_nxt = r_vc;
    if (w_h_last) w_vc_nxt = w_v_last ? '0 : r_vc + coord_t'(1);
  end

  // Reset parks on the last back-porch pixel so release lands exactly on (0,0).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc           <= H_LAST;
      r_vc           <= V_LAST;
      r_blank        <= 1'b0;
      r_hs           <= 1'b1;
      r_vs           <= 1'b1;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      r_hc           <= w_hc_nxt;
      r_vc           <= w_vc_nxt;
      r_blank        <= (32'(w_hc_nxt) < H_VISIBLE) && (32'(w_vc_nxt) < V_VISIBLE);
      r_hs           <= !in_range(32'(w_hc_nxt), H_SYNC_LO, H_SYNC_HI);
      r_vs           <= !in_range(32'(w_vc_nxt), V_SYNC_LO, V_SYNC_HI);
      r_frame_start  <= (w_hc_nxt == '0) && (w_vc_nxt == '0);
      r_vblank_start <= (w_hc_nxt == '0) && (32'(w_vc_nxt) == V_VISIBLE);
    end
  end

  assign DrawX        = r_hc;
  assign DrawY        = r_vc;
  assign frame_start  = r_frame_start;
  assign vblank_start = r_vblank_start;

`ifdef VGA_PIPE_ALIGN_EN
  logic [2:0] w_dly_out;

  // Delay {blank,hs,vs} to match the renderer's ROM read plus colour register.
  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DLY),
    .RESET_VAL (3'b011)
  ) u_sync_dly (
    .i_clk   (vga_clk),
    .i_reset (reset),
    .i_data  ({r_blank, r_hs, r_vs}),
    .o_data  (w_dly_out)
  );

  assign blank = w_dly_out[2];
  assign hs    = w_dly_out[1];
  assign vs    = w_dly_out[0];
`else
  assign blank = r_blank;
  assign hs    = r_hs;
  assign vs    = r_vs;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size and reduced-size instances against a position-count model.
module tb_vga_timing_gen;

  localparam int unsigned BHT = 800;
  localparam int unsigned BVT = 525;
  localparam int unsigned BTOT = BHT * BVT;
  localparam int unsigned SHT = 12;
  localparam int unsigned SVT = 7;
  localparam int unsigned STOT = SHT * SVT;
`ifdef VGA_PIPE_ALIGN_EN
  localparam int unsigned TB_DLY = 2;
`else
  localparam int unsigned TB_DLY = 0;
`endif

  typedef struct {
    int unsigned hv, hfp, hsy, ht, vv, vfp, vsy;
  } tim_t;

  typedef struct {
    logic rst;
    int   x, y, bl, hs, vs, fs, vbs;
  } vec_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_b, rst_s;
  logic [9:0] bx, by, sx, sy;
  logic       b_blank, b_hs, b_vs, b_fs, b_vbs;
  logic       s_blank, s_hs, s_vs, s_fs, s_vbs;

  vga_timing_gen u_big (
    .vga_clk(clk), .reset(rst_b), .DrawX(bx), .DrawY(by), .blank(b_blank),
    .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .vblank_start(b_vbs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .vga_clk(clk), .reset(rst_s), .DrawX(sx), .DrawY(sy), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .vblank_start(s_vbs)
  );

  tim_t tb_big = '{640, 16, 96, 800, 480, 10, 2};
  tim_t tb_sml = '{8, 1, 2, 12, 4, 1, 1};

  int n_cmp = 0;
  int n_err = 0;

  // Reference: raster position = cycles since reset release, modulo the frame length.
  int unsigned pos_b = 0, pos_s = 0;
  logic [2:0]  hist_b [0:3];
  logic [2:0]  hist_s [0:3];

  function automatic logic [2:0] dec(input tim_t t, input int unsigned pos);
    int unsigned x, y;
    logic [2:0] r;
    x = pos % t.ht;
    y = pos / t.ht;
    r[2] = (x < t.hv) && (y < t.vv);
    r[1] = !((x >= t.hv + t.hfp) && (x < t.hv + t.hfp + t.hsy));
    r[0] = !((y >= t.vv + t.vfp) && (y < t.vv + t.vfp + t.vsy));
    return r;
  endfunction

  always @(posedge clk) begin
    int unsigned np;
    np = rst_b ? BTOT - 1 : (pos_b + 1) % BTOT;
    pos_b <= np;
    for (int i = 3; i > 0; i--) hist_b[i] <= rst_b ? 3'b011 : hist_b[i-1];
    hist_b[0] <= dec(tb_big, np);
  end

  always @(posedge clk) begin
    int unsigned np;
    np = rst_s ? STOT - 1 : (pos_s + 1) % STOT;
    pos_s <= np;
    for (int i = 3; i > 0; i--) hist_s[i] <= rst_s ? 3'b011 : hist_s[i-1];
    hist_s[0] <= dec(tb_sml, np);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 50) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_models();
    logic [2:0] eb, es;
    eb = hist_b[TB_DLY];
    es = hist_s[TB_DLY];
    chk("big_x",     int'(bx),      int'(pos_b % BHT));
    chk("big_y",     int'(by),      int'(pos_b / BHT));
    chk("big_blank", int'(b_blank), int'(eb[2]));
    chk("big_hs",    int'(b_hs),    int'(eb[1]));
    chk("big_vs",    int'(b_vs),    int'(eb[0]));
    chk("big_fs",    int'(b_fs),    int'(pos_b == 0));
    chk("big_vbs",   int'(b_vbs),   int'(pos_b == 480 * BHT));
    chk("sml_x",     int'(sx),      int'(pos_s % SHT));
    chk("sml_y",     int'(sy),      int'(pos_s / SHT));
    chk("sml_blank", int'(s_blank), int'(es[2]));
    chk("sml_hs",    int'(s_hs),    int'(es[1]));
    chk("sml_vs",    int'(s_vs),    int'(es[0]));
    chk("sml_fs",    int'(s_fs),    int'(pos_s == 0));
    chk("sml_vbs",   int'(s_vbs),   int'(pos_s == 4 * SHT));
  endtask

  task automatic tick();
    @(negedge clk);
    check_models();
  endtask

  vec_t tv [7];
  int   guard, wraps, bl, hl, first_hl, row_cyc, px, py, vl, fvx, fvy, vbc;

  initial begin
    rst_b = 1'b1;
    rst_s = 1'b1;

    // Reset held three cycles, then the first pixels of frame 0.
    tv[0] = '{1'b1, 799, 524, 0, 1, 1, 0, 0};
    tv[1] = '{1'b1, 799, 524, 0, 1, 1, 0, 0};
    tv[2] = '{1'b1, 799, 524, 0, 1, 1, 0, 0};
    tv[3] = '{1'b0, 0, 0, int'(TB_DLY == 0), 1, 1, 1, 0};
    tv[4] = '{1'b0, 1, 0, int'(TB_DLY <= 1), 1, 1, 0, 0};
    tv[5] = '{1'b0, 2, 0, 1, 1, 1, 0, 0};
    tv[6] = '{1'b0, 3, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      rst_b = tv[i].rst;
      rst_s = tv[i].rst;
      tick();
      chk("tv_x",     int'(bx),      tv[i].x);
      chk("tv_y",     int'(by),      tv[i].y);
      chk("tv_blank", int'(b_blank), tv[i].bl);
      chk("tv_hs",    int'(b_hs),    tv[i].hs);
      chk("tv_vs",    int'(b_vs),    tv[i].vs);
      chk("tv_fs",    int'(b_fs),    tv[i].fs);
      chk("tv_vbs",   int'(b_vbs),   tv[i].vbs);
    end

    // One full line (row 1) on the full-size instance, plus both line wraps.
    guard = 0; wraps = 0; bl = 0; hl = 0; first_hl = -1; row_cyc = 0;
    px = int'(bx); py = int'(by);
    while (by != 10'd2 && guard < 2000) begin
      tick();
      guard++;
      if (bx == 10'd0) begin
        wraps++;
        chk("line_wrap_prev_x", px, 799);
        chk("line_wrap_y_inc", int'(by), py + 1);
      end
      if (by == 10'd1) begin
        row_cyc++;
        if (b_blank) bl++;
        if (!b_hs) begin
          if (first_hl < 0) first_hl = int'(bx);
          hl++;
        end
      end
      px = int'(bx);
      py = int'(by);
    end
    chk("line_reached_row2", int'(by), 2);
    chk("line_wraps", wraps, 2);
    chk("line_len", row_cyc, 800);
    chk("line_blank_cnt", bl, 640);
    chk("line_hs_cnt", hl, 96);
    chk("line_hs_start_x", first_hl, 656 + int'(TB_DLY));

    // One full reduced frame: vs width/position, vblank strobe, frame period.
    guard = 0;
    while (!s_fs && guard < 300) begin
      tick();
      guard++;
    end
    chk("sframe_fs_seen", int'(s_fs), 1);
    vl = 0; fvx = -1; fvy = -1; vbc = 0;
    for (int k = 0; k < int'(STOT); k++) begin
      if (!s_vs) begin
        if (vl == 0) begin
          fvx = int'(sx);
          fvy = int'(sy);
        end
        vl++;
      end
      if (s_vbs) begin
        vbc++;
        chk("sframe_vbs_x", int'(sx), 0);
        chk("sframe_vbs_y", int'(sy), 4);
      end
      if (k > 0) chk("sframe_fs_extra", int'(s_fs), 0);
      tick();
    end
    chk("sframe_period_fs", int'(s_fs), 1);
    chk("sframe_vs_cnt", vl, 12);
    chk("sframe_vs_start_x", fvx, int'(TB_DLY));
    chk("sframe_vs_start_y", fvy, 5);
    chk("sframe_vbs_cnt", vbc, 1);

    // Single-cycle reset mid-frame on the reduced instance.
    guard = 0;
    while (!(sx == 10'd5 && sy == 10'd3) && guard < 200) begin
      tick();
      guard++;
    end
    chk("srst_found_pos", int'(sx == 10'd5 && sy == 10'd3), 1);
    rst_s = 1'b1;
    tick();
    chk("srst_x", int'(sx), 11);
    chk("srst_y", int'(sy), 6);
    chk("srst_blank", int'(s_blank), 0);
    chk("srst_hs", int'(s_hs), 1);
    chk("srst_vs", int'(s_vs), 1);
    chk("srst_fs", int'(s_fs), 0);
    rst_s = 1'b0;
    tick();
    chk("srst_rel_x", int'(sx), 0);
    chk("srst_rel_y", int'(sy), 0);
    chk("srst_rel_fs", int'(s_fs), 1);

    // Single-cycle reset mid-line on the full-size instance.
    guard = 0;
    while (bx != 10'd123 && guard < 1000) begin
      tick();
      guard++;
    end
    chk("brst_found_pos", int'(bx), 123);
    rst_b = 1'b1;
    tick();
    chk("brst_x", int'(bx), 799);
    chk("brst_y", int'(by), 524);
    chk("brst_blank", int'(b_blank), 0);
    chk("brst_hs", int'(b_hs), 1);
    chk("brst_vs", int'(b_vs), 1);
    rst_b = 1'b0;
    tick();
    chk("brst_rel_x", int'(bx), 0);
    chk("brst_rel_y", int'(by), 0);
    chk("brst_rel_fs", int'(b_fs), 1);

    // Random reset pulses against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst_s = ($urandom_range(0, 39) == 0);
      rst_b = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst_s = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 200; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Produces the raster scan that every pixel renderer in the design consumes: pixel coordinates DrawX/DrawY, the display-active qualifier blank, and the active-low VGA sync pulses. It runs at the 25 MHz pixel clock (640x480@60 default). It also emits per-frame strobes so game logic can update sprite and tank state during vertical blanking. It sits between the clock generator and all sprite/overlay renderers and the VGA pins.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DLY, 2, sync/blank delay in cycles; used only under VGA_PIPE_ALIGN_EN

Ports:
vga_clk  in  1  pixel clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
DrawX  out  10  current horizontal count 0..H_TOTAL-1
DrawY  out  10  current vertical count 0..V_TOTAL-1
blank  out  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
hs  out  1  horizontal sync, active low
vs  out  1  vertical sync, active low
frame_start  out  1  one-cycle pulse at (0,0)
vblank_start  out  1  one-cycle pulse at (0,V_VISIBLE)

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024; elaboration-time assertion otherwise.
- Registers:
  - hc and vc counters drive DrawX/DrawY.
  - All other outputs are registered decodes of the next counter values, so they are valid in the same cycle as the matching DrawX/DrawY (zero relative latency).
- Counting:
  - hc increments every cycle. At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - At hc==H_TOTAL-1 and vc==V_TOTAL-1, both wrap to 0.
  - No enable input; the counter free-runs.
- Sync decode:
  - hs=0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs=0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491), for whole lines, aligned to the hc==0 boundary.
- Strobes:
  - frame_start=1 only when (hc,vc)=(0,0).
  - vblank_start=1 only when (hc,vc)=(0,V_VISIBLE).
- Reset (synchronous; on any edge with reset=1, including mid-frame):
  - hc<=H_TOTAL-1, vc<=V_TOTAL-1, so DrawX=799, DrawY=524.
  - blank=0, hs=1, vs=1, frame_start=0, vblank_start=0.
  - These outputs are consistent with the decode of that back-porch position.
- First edge after reset deasserts: (0,0), blank=1, frame_start=1. There is no partial frame after reset.
- Frame period is exactly H_TOTAL*V_TOTAL = 420000 cycles. Frames are seamless: no dead cycles at line or frame wrap.

Optional Feature:
VGA_PIPE_ALIGN_EN
- Defined:
  - hs, vs and blank pass through a PIPE_DLY-stage delay line after the decode registers.
  - This matches renderers with a synchronous ROM read plus a colour output register (2 cycles).
  - DrawX/DrawY, frame_start and vblank_start are not delayed.
  - On reset, delay stages load their inactive values (blank 0, hs 1, vs 1).
- Undefined: no delay line; the behaviour above applies exactly.

Decomposition:
- Package vga_pkg holds:
  - the 640x480 timing localparams and derived H_TOTAL/V_TOTAL;
  - typedef coord_t = logic [9:0];
  - the PIPE_DLY default.
- Sub-module vga_delay_line (parameterised WIDTH, DEPTH; synchronous active-high reset with a RESET_VAL parameter) is instantiated only under VGA_PIPE_ALIGN_EN.

Test Plan:
- Reset held 3 cycles, then released: during reset DrawX=799, DrawY=524, blank=0, hs=1, vs=1. First cycle after release shows DrawX=0, DrawY=0, blank=1, frame_start=1.
- Run one line: blank=1 for DrawX 0..639 and 0 for 640..799. hs=0 for exactly 96 cycles starting at DrawX=656. DrawX goes 799->0 while DrawY goes 0->1.
- Run full frame: vs=0 for exactly 1600 cycles starting at (0,490). vblank_start pulses once at (0,480). The next frame_start arrives exactly 420000 cycles after the first.
- Assert reset at (123,200) for 1 cycle: the next cycle shows (799,524) with inactive outputs, and the cycle after shows (0,0) with frame_start=1.
- With VGA_PIPE_ALIGN_EN, PIPE_DLY=2: blank rises 2 cycles after DrawX=0 and DrawY=0. hs falls when DrawX=658. frame_start timing is unchanged.
- Reduced parameters (H: 8/1/2/1, V: 4/1/1/1): DrawX wraps after 12 cycles and DrawY after 7 lines; all decode boundaries are checked against a reference model.
